leiwand_rv32_lsu: RTL and testbench

Load/store unit sitting directly upstream of the word-addressed data memory (valid/ready/wen/addr/wdata/rdata port).
- Takes one byte/half/word load or store request from the core's execute stage.
- Drives the memory with a word-aligned address, byte-lane write enables and lane-replicated write data.
- Waits for memory ready, then returns sign- or zero-extended load data, or an error code, to the core.
- RV32 only; RV64 access is out of scope.

---
 rtl/leiwand_rv32_lsu_pkg.sv | 18 +
 rtl/leiwand_rv32_lsu_if.sv | 31 +++
 rtl/leiwand_rv32_lsu_align.sv | 67 ++++++
 rtl/leiwand_rv32_lsu.sv | 144 ++++++++++++++
 tb/tb_leiwand_rv32_lsu.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/leiwand_rv32_lsu_pkg.sv
// Shared funct3 codes, response error codes and FSM states for the RV32 LSU.
package leiwand_rv32_lsu_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] RSP_ERR_OK      = 2'b00;
  localparam logic [1:0] RSP_ERR_MISAL   = 2'b01;
  localparam logic [1:0] RSP_ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] RSP_ERR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} lsu_state_e;
endpackage

// File: rtl/leiwand_rv32_lsu_if.sv
// Core-side request/response and memory-side bus bundles for the LSU.
interface leiwand_rv32_lsu_core_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic [1:0]      rsp_err;

  modport master (output req_valid, req_we, req_funct3, req_addr, req_wdata,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_funct3, req_addr, req_wdata,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface leiwand_rv32_lsu_mem_if #(parameter int XLEN = 32);
  logic            mem_valid;
  logic [3:0]      mem_wen;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (output mem_valid, mem_wen, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_valid, mem_wen, mem_addr, mem_wdata,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/leiwand_rv32_lsu_align.sv
// Byte-lane steering: store enables/replication, request checks, load extraction/extension.
module leiwand_rv32_lsu_align
  import leiwand_rv32_lsu_pkg::*;
(
  input  logic        st_we_i,
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_wen_o,
  output logic [31:0] st_wdata_o,
  output logic        misal_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_wen_o   = 4'b0000;
    st_wdata_o = '0;
    misal_o    = 1'b0;
    illegal_o  = 1'b0;
    if (st_we_i) begin
      case (st_funct3_i)
        F3_SB: begin
          st_wen_o   = 4'b0001 << st_off_i;
          st_wdata_o = {4{st_data_i[7:0]}};
        end
        F3_SH: begin
          st_wen_o   = 4'b0011 << {st_off_i[1], 1'b0};
          st_wdata_o = {2{st_data_i[15:0]}};
          misal_o    = st_off_i[0];
        end
        F3_SW: begin
          st_wen_o   = 4'b1111;
          st_wdata_o = st_data_i;
          misal_o    = |st_off_i;
        end
        default: illegal_o = 1'b1;
      endcase
    end else begin
      case (st_funct3_i)
        F3_LB, F3_LBU: misal_o = 1'b0;
        F3_LH, F3_LHU: misal_o = st_off_i[0];
        F3_LW:         misal_o = |st_off_i;
        default:       illegal_o = 1'b1;
      endcase
    end
  end

  assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

  always_comb begin
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  ld_data_o = {24'h0, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  ld_data_o = {16'h0, ld_half};
      F3_LW:   ld_data_o = ld_rdata_i;
      default: ld_data_o = '0;
    endcase
  end
endmodule

// File: rtl/leiwand_rv32_lsu.sv
// RV32 load/store unit: IDLE/ACCESS/RESP sequencer with memory-ready timeout.
module leiwand_rv32_lsu
  import leiwand_rv32_lsu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  leiwand_rv32_lsu_core_if.slave  core,
  leiwand_rv32_lsu_mem_if.master  mem
);
  localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int TMAX = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  lsu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            mem_valid_q, mem_valid_d;
  logic [3:0]      mem_wen_q, mem_wen_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]      rsp_err_q, rsp_err_d;

  logic [3:0]      st_wen;
  logic [XLEN-1:0] st_wdata, ld_data;
  logic            misal, illegal;

  leiwand_rv32_lsu_align u_align (
    .st_we_i     (core.req_we),
    .st_funct3_i (core.req_funct3),
    .st_off_i    (core.req_addr[1:0]),
    .st_data_i   (core.req_wdata),
    .st_wen_o    (st_wen),
    .st_wdata_o  (st_wdata),
    .misal_o     (misal),
    .illegal_o   (illegal),
    .ld_funct3_i (f3_q),
    .ld_off_i    (off_q),
    .ld_rdata_i  (mem.mem_rdata),
    .ld_data_o   (ld_data)
  );

  // Blocking on mem_ready keeps a stale ready (previous access or across reset) from completing a new one.
  assign core.req_ready = (state_q == ST_IDLE) && !mem.mem_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    mem_valid_d = mem_valid_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: if (core.req_valid && core.req_ready) begin
        if (illegal || misal) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = illegal ? RSP_ERR_ILLEGAL : RSP_ERR_MISAL;
          state_d     = ST_RESP;
        end else begin
          we_d        = core.req_we;
          f3_d        = core.req_funct3;
          off_d       = core.req_addr[1:0];
          mem_valid_d = 1'b1;
          mem_wen_d   = st_wen;
          mem_addr_d  = {core.req_addr[XLEN-1:2], 2'b00};
          mem_wdata_d = st_wdata;
          cnt_d       = '0;
          state_d     = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem.mem_ready) begin
          mem_valid_d = 1'b0;
          mem_wen_d   = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ld_data;
          rsp_err_d   = RSP_ERR_OK;
          state_d     = ST_RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == CW'(TMAX)) begin
          mem_valid_d = 1'b0;
          mem_wen_d   = 4'b0000;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = RSP_ERR_TIMEOUT;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      mem_valid_q <= 1'b0;
      mem_wen_q   <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      mem_valid_q <= mem_valid_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign mem.mem_valid  = mem_valid_q;
  assign mem.mem_wen    = mem_wen_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wdata  = mem_wdata_q;
  assign core.rsp_valid = rsp_valid_q;
  assign core.rsp_rdata = rsp_rdata_q;
  assign core.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_leiwand_rv32_lsu.sv
// LSU bench: 256-word memory model, byte-array reference model, directed and random accesses.
module tb_leiwand_rv32_lsu;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  leiwand_rv32_lsu_core_if cif ();
  leiwand_rv32_lsu_mem_if  mif ();

  leiwand_rv32_lsu #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .core  (cif),
    .mem   (mif)
  );

  // Memory model: synchronous read, ready registered one cycle after valid, not reset.
  bit [31:0] mem [256];
  bit        stall;
  always @(posedge clk) begin
    if (mif.mem_valid)
      for (int i = 0; i < 4; i++)
        if (mif.mem_wen[i]) mem[mif.mem_addr[9:2]][8*i +: 8] <= mif.mem_wdata[8*i +: 8];
    mif.mem_rdata <= mem[mif.mem_addr[9:2]];
    mif.mem_ready <= mif.mem_valid && !stall;
  end

  bit [7:0] rmem [1024];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory with size/sign rules; commits stores only on success.
  task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       output logic [1:0] err, output logic [31:0] rd,
                       output logic [3:0] wen, output logic [31:0] wdx, output int lat);
    int size;
    int base;
    size = 1 << f3[1:0];
    base = int'(a[9:0]);
    rd = 0; wen = 0; wdx = 0;
    if (f3[1:0] == 2'd3 || (we && f3[2]) || (!we && f3 == 3'b110)) begin
      err = 2'b11; lat = 1;
    end else if ((base % size) != 0) begin
      err = 2'b01; lat = 1;
    end else if (stall) begin
      err = 2'b10; lat = TO + 1;
    end else begin
      err = 2'b00; lat = 3;
      if (we) begin
        for (int i = 0; i < size; i++) begin
          rmem[base + i] = wd[8*i +: 8];
          wen[(base % 4) + i] = 1'b1;
        end
        for (int j = 0; j < 4; j++) wdx[8*j +: 8] = wd[8*(j % size) +: 8];
      end else begin
        for (int i = 0; i < size; i++) rd[8*i +: 8] = rmem[base + i];
        if (!f3[2] && size < 4 && rd[8*size-1]) rd = rd | (32'hFFFFFFFF << (8*size));
      end
    end
  endtask

  // One request issued at a negedge; returns at the negedge after the response pulse.
  task automatic run(input string tag, input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, output logic [31:0] rd_o);
    logic [1:0] err_e; logic [31:0] rd_e; logic [3:0] wen_e; logic [31:0] wdx_e; int lat_e;
    logic [3:0] wen_s; logic [31:0] wd_s, addr_s;
    bit mv; bit got; int n; int lat;
    model(we, f3, a, wd, err_e, rd_e, wen_e, wdx_e, lat_e);
    cif.req_we = we; cif.req_funct3 = f3; cif.req_addr = a; cif.req_wdata = wd; cif.req_valid = 1'b1;
    n = 0;
    while (!cif.req_ready && n < 50) begin @(negedge clk); n++; end
    chk({tag, "/accept"}, 32'(cif.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cif.req_valid = 1'b0;
    lat = 1; mv = 0; got = 0; wen_s = 0; wd_s = 0; addr_s = 0; rd_o = 'x;
    while (!got && lat < 40) begin
      if (mif.mem_valid && !mv) begin
        mv = 1; wen_s = mif.mem_wen; wd_s = mif.mem_wdata; addr_s = mif.mem_addr;
      end
      if (cif.rsp_valid) begin
        got = 1; rd_o = cif.rsp_rdata;
        chk({tag, "/err"}, 32'(cif.rsp_err), 32'(err_e));
        chk({tag, "/rdata"}, cif.rsp_rdata, rd_e);
      end else begin
        @(negedge clk); lat++;
      end
    end
    chk({tag, "/latency"}, 32'(lat), 32'(lat_e));
    chk({tag, "/mem_valid_seen"}, 32'(mv), 32'(err_e == 2'b00 || err_e == 2'b10));
    if (err_e == 2'b00) begin
      chk({tag, "/mem_addr"}, addr_s, {a[31:2], 2'b00});
      chk({tag, "/mem_wen"}, 32'(wen_s), 32'(wen_e));
      if (we) chk({tag, "/mem_wdata"}, wd_s, wdx_e);
    end
    @(negedge clk);
    chk({tag, "/rsp_pulse"}, 32'(cif.rsp_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0] e2; logic [31:0] r2; logic [3:0] w2; logic [31:0] x2; int l2;
    int cyc;
    rst_n = 1'b0; stall = 1'b0;
    cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_funct3 = 3'b0;
    cif.req_addr = '0; cif.req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset/mem_valid", 32'(mif.mem_valid), 32'd0);
    chk("reset/mem_wen", 32'(mif.mem_wen), 32'd0);
    chk("reset/mem_addr", mif.mem_addr, 32'd0);
    chk("reset/mem_wdata", mif.mem_wdata, 32'd0);
    chk("reset/rsp_valid", 32'(cif.rsp_valid), 32'd0);
    chk("reset/rsp_rdata", cif.rsp_rdata, 32'd0);
    chk("reset/rsp_err", 32'(cif.rsp_err), 32'd0);
    chk("reset/req_ready", 32'(cif.req_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run("sw10", 1, 3'b010, 32'h10, 32'hDEADBEEF, rd);
    run("lw10", 0, 3'b010, 32'h10, 32'h0, rd);
    chk("lw10/const", rd, 32'hDEADBEEF);
    run("sb13", 1, 3'b000, 32'h13, 32'h000000A5, rd);
    run("lb13", 0, 3'b000, 32'h13, 32'h0, rd);
    chk("lb13/const", rd, 32'hFFFFFFA5);
    run("lbu13", 0, 3'b100, 32'h13, 32'h0, rd);
    chk("lbu13/const", rd, 32'h000000A5);
    run("lw10b", 0, 3'b010, 32'h10, 32'h0, rd);
    chk("lw10b/const", rd, 32'hA5ADBEEF);
    run("sh12", 1, 3'b001, 32'h12, 32'h00008001, rd);
    run("lh12", 0, 3'b001, 32'h12, 32'h0, rd);
    chk("lh12/const", rd, 32'hFFFF8001);
    run("lhu12", 0, 3'b101, 32'h12, 32'h0, rd);
    chk("lhu12/const", rd, 32'h00008001);
    run("lw11_misal", 0, 3'b010, 32'h11, 32'h0, rd);
    run("sh13_misal", 1, 3'b001, 32'h13, 32'h1234, rd);
    run("ld011_ill", 0, 3'b011, 32'h10, 32'h0, rd);
    run("sb_ill", 1, 3'b100, 32'h10, 32'h0, rd);

    stall = 1'b1;
    run("lw_timeout", 0, 3'b010, 32'h20, 32'h0, rd);
    chk("timeout/mem_valid_after", 32'(mif.mem_valid), 32'd0);
    chk("timeout/req_ready_after", 32'(cif.req_ready), 32'd1);
    stall = 1'b0;

    // req_valid held across two requests: second accept waits for mem_ready to fall.
    cif.req_we = 1; cif.req_funct3 = 3'b010; cif.req_addr = 32'h40; cif.req_wdata = 32'h13579BDF;
    cif.req_valid = 1'b1;
    model(1, 3'b010, 32'h40, 32'h13579BDF, e2, r2, w2, x2, l2);
    chk("b2b/first_ready", 32'(cif.req_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    cyc = 1;
    cif.req_we = 0; cif.req_addr = 32'h40; cif.req_wdata = 32'h0;
    while (!cif.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("b2b/second_accept_cycle", 32'(cyc), 32'd4);
    @(posedge clk); @(negedge clk);
    cif.req_valid = 1'b0;
    cyc = 1;
    while (!cif.rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    chk("b2b/second_latency", 32'(cyc), 32'd3);
    chk("b2b/second_rdata", cif.rsp_rdata, 32'h13579BDF);
    @(negedge clk);

    // Reset pulsed while ACCESS sees mem_ready high.
    cif.req_we = 0; cif.req_funct3 = 3'b010; cif.req_addr = 32'h40; cif.req_valid = 1'b1;
    cyc = 0;
    while (!cif.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
    @(posedge clk); @(negedge clk);
    cif.req_valid = 1'b0;
    chk("rst/mem_valid_c1", 32'(mif.mem_valid), 32'd1);
    @(negedge clk);
    chk("rst/mem_ready_c2", 32'(mif.mem_ready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst/mem_valid_async", 32'(mif.mem_valid), 32'd0);
    chk("rst/req_ready_stale", 32'(cif.req_ready), 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst/no_rsp", 32'(cif.rsp_valid), 32'd0);
    end
    chk("rst/req_ready_after", 32'(cif.req_ready), 32'd1);

    // Random accesses over the 1 KiB memory; reads see model state from all earlier stores.
    for (int t = 0; t < 150; t++) begin
      logic [31:0] ra;
      logic [2:0] rf;
      bit rw;
      rw = 1'($urandom_range(0, 1));
      rf = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) rf[1:0] = 2'($urandom_range(0, 2));
      ra = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) != 0) ra[1:0] = ra[1:0] & ~((2'(1) << rf[1:0]) - 2'd1);
      run("rand", rw, rf, ra, $urandom, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
